// File: rtl/cti_resolve_queue_if.sv
// Handshake bundle between fetch/writeback/commit and the CTI resolve queue.
// The master side drives requests; the slave side is the queue itself.
interface cti_resolve_queue_if #(
    parameter int SIZE_CTI_LOG    = 4,
    parameter int SIZE_PC         = 32,
    parameter int BRANCH_TYPE_LOG = 2
);
    logic                       allocValid;
    logic [SIZE_CTI_LOG-1:0]    allocID;
    logic                       full;

    logic                       exeCtrlValid;
    logic [SIZE_CTI_LOG-1:0]    exeCtiID;
    logic [SIZE_PC-1:0]         exeCtrlPC;
    logic [SIZE_PC-1:0]         exeCtrlNPC;
    logic                       exeCtrlDir;
    logic [BRANCH_TYPE_LOG-1:0] exeCtrlType;

    logic                       commitCti;
    logic                       recoverFlag;
    logic [SIZE_CTI_LOG-1:0]    recoverCtiID;
    logic                       exceptionFlag;

    logic                       updateEn;
    logic [SIZE_PC-1:0]         updatePC;
    logic [SIZE_PC-1:0]         updateNPC;
    logic                       updateDir;
    logic [BRANCH_TYPE_LOG-1:0] updateType;

    logic [SIZE_CTI_LOG:0]      count;
    logic                       protoErr;

    modport master (
        output allocValid, exeCtrlValid, exeCtiID, exeCtrlPC, exeCtrlNPC,
               exeCtrlDir, exeCtrlType, commitCti, recoverFlag, recoverCtiID,
               exceptionFlag,
        input  allocID, full, updateEn, updatePC, updateNPC, updateDir,
               updateType, count, protoErr
    );

    modport slave (
        input  allocValid, exeCtrlValid, exeCtiID, exeCtrlPC, exeCtrlNPC,
               exeCtrlDir, exeCtrlType, commitCti, recoverFlag, recoverCtiID,
               exceptionFlag,
        output allocID, full, updateEn, updatePC, updateNPC, updateDir,
               updateType, count, protoErr
    );
endinterface

// File: rtl/cti_resolve_queue.sv
// In-order queue of control-transfer instructions: fetch allocates, writeback
// resolves, commit drains the head to the predictor as a registered update.
module cti_resolve_queue #(
    parameter int CTI_DEPTH       = 16,
    parameter int SIZE_CTI_LOG    = 4,
    parameter int SIZE_PC         = 32,
    parameter int BRANCH_TYPE_LOG = 2
) (
    input logic                clk,
    input logic                reset,
    cti_resolve_queue_if.slave bus
);
    localparam int PW = SIZE_CTI_LOG + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]              headPtr, tailPtr, headNext, tailNext;
    logic [PW-1:0]              count, recoverKept;
    logic [SIZE_CTI_LOG-1:0]    headIdx, tailIdx, wbOffset, recoverOffset;
    logic                       full, wbInWindow, headBypass, headResolved;
    logic                       allocEn, commitEn, commitBad;

    logic [CTI_DEPTH-1:0]       resolved;
    logic [SIZE_PC-1:0]         pcMem   [CTI_DEPTH];
    logic [SIZE_PC-1:0]         npcMem  [CTI_DEPTH];
    logic                       dirMem  [CTI_DEPTH];
    logic [BRANCH_TYPE_LOG-1:0] typeMem [CTI_DEPTH];

    logic                       updateEnReg, updateDirReg, protoErrReg;
    logic [SIZE_PC-1:0]         updatePCReg, updateNPCReg;
    logic [BRANCH_TYPE_LOG-1:0] updateTypeReg;

    assign headIdx = headPtr[SIZE_CTI_LOG-1:0];
    assign tailIdx = tailPtr[SIZE_CTI_LOG-1:0];
    assign count   = tailPtr - headPtr;
    assign full    = (count == PW'(CTI_DEPTH));

    // A writeback is live only if its ID sits within [head, tail) on the ring.
    assign wbOffset      = bus.exeCtiID - headIdx;
    assign wbInWindow    = bus.exeCtrlValid && ({1'b0, wbOffset} < count);
    assign headBypass    = wbInWindow && (bus.exeCtiID == headIdx);
    assign headResolved  = resolved[headIdx] || headBypass;

    assign commitEn  = bus.commitCti && (count != '0) && headResolved;
    assign commitBad = bus.commitCti && !commitEn;
    assign allocEn   = bus.allocValid && !full && !bus.recoverFlag && !bus.exceptionFlag;

    // The mispredicting CTI stays live, so recovery keeps 1..DEPTH entries counted from the old head.
    assign recoverOffset = bus.recoverCtiID - headIdx;
    assign recoverKept   = {1'b0, recoverOffset} + PW'(1);

    assign headNext = headPtr + PW'(commitEn);

    always_comb begin
        tailNext = tailPtr;
        if (bus.exceptionFlag)
            tailNext = headNext;
        else if (bus.recoverFlag)
            tailNext = headPtr + recoverKept;
        else if (allocEn)
            tailNext = tailPtr + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr       <= '0;
            tailPtr       <= '0;
            resolved      <= '0;
            protoErrReg   <= 1'b0;
            updateEnReg   <= 1'b0;
            updatePCReg   <= '0;
            updateNPCReg  <= '0;
            updateDirReg  <= 1'b0;
            updateTypeReg <= '0;
        end else begin
            headPtr <= headNext;
            tailPtr <= tailNext;
            if (allocEn)
                resolved[tailIdx] <= 1'b0;
            if (wbInWindow)
                resolved[bus.exeCtiID] <= 1'b1;
            if (commitBad)
                protoErrReg <= 1'b1;
            updateEnReg <= commitEn;
            if (commitEn) begin
                updatePCReg   <= headBypass ? bus.exeCtrlPC   : pcMem[headIdx];
                updateNPCReg  <= headBypass ? bus.exeCtrlNPC  : npcMem[headIdx];
                updateDirReg  <= headBypass ? bus.exeCtrlDir  : dirMem[headIdx];
                updateTypeReg <= headBypass ? bus.exeCtrlType : typeMem[headIdx];
            end
        end
    end

    // Payload storage needs no reset; the resolved bits gate every use.
    always_ff @(posedge clk) begin
        if (wbInWindow) begin
            pcMem[bus.exeCtiID]   <= bus.exeCtrlPC;
            npcMem[bus.exeCtiID]  <= bus.exeCtrlNPC;
            dirMem[bus.exeCtiID]  <= bus.exeCtrlDir;
            typeMem[bus.exeCtiID] <= bus.exeCtrlType;
        end
    end

    assign bus.allocID    = tailIdx;
    assign bus.full       = full;
    assign bus.count      = count;
    assign bus.protoErr   = protoErrReg;
    assign bus.updateEn   = updateEnReg;
    assign bus.updatePC   = updatePCReg;
    assign bus.updateNPC  = updateNPCReg;
    assign bus.updateDir  = updateDirReg;
    assign bus.updateType = updateTypeReg;
endmodule

// File: tb/tb_cti_resolve_queue.sv
// Directed bench for cti_resolve_queue: fill/full, ordered drain, protocol
// errors, recovery, ring wrap and exception flush.
module tb_cti_resolve_queue;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checkCount = 0;
    int   errorCount = 0;

    cti_resolve_queue_if #(.SIZE_CTI_LOG(4), .SIZE_PC(32), .BRANCH_TYPE_LOG(2)) bus ();

    cti_resolve_queue #(
        .CTI_DEPTH(16), .SIZE_CTI_LOG(4), .SIZE_PC(32), .BRANCH_TYPE_LOG(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.allocValid    = 1'b0;
        bus.exeCtrlValid  = 1'b0;
        bus.exeCtiID      = '0;
        bus.exeCtrlPC     = '0;
        bus.exeCtrlNPC    = '0;
        bus.exeCtrlDir    = 1'b0;
        bus.exeCtrlType   = '0;
        bus.commitCti     = 1'b0;
        bus.recoverFlag   = 1'b0;
        bus.recoverCtiID  = '0;
        bus.exceptionFlag = 1'b0;
    endtask

    // Holds the currently driven inputs across one rising edge, then idles them.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
    endtask

    task automatic writeback(input int id, input int pc, input int npc,
                             input int dir, input int typ);
        bus.exeCtrlValid = 1'b1;
        bus.exeCtiID     = 4'(id);
        bus.exeCtrlPC    = 32'(pc);
        bus.exeCtrlNPC   = 32'(npc);
        bus.exeCtrlDir   = 1'(dir);
        bus.exeCtrlType  = 2'(typ);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rstAllocID",  32'(bus.allocID),  0);
        checkOutput("rstFull",     32'(bus.full),     0);
        checkOutput("rstCount",    32'(bus.count),    0);
        checkOutput("rstUpdateEn", 32'(bus.updateEn), 0);
        checkOutput("rstUpdatePC", 32'(bus.updatePC), 0);
        checkOutput("rstProtoErr", 32'(bus.protoErr), 0);

        $display("[TB] fill to full");
        for (int i = 0; i < 16; i++) begin
            checkOutput("fillAllocID", 32'(bus.allocID), i);
            if (i == 15) checkOutput("fillNotFull15", 32'(bus.full), 0);
            bus.allocValid = 1'b1;
            applyStimulus();
        end
        checkOutput("fullFlag",  32'(bus.full),  1);
        checkOutput("fullCount", 32'(bus.count), 16);
        bus.allocValid = 1'b1;
        applyStimulus();
        checkOutput("allocWhileFullCount", 32'(bus.count),   16);
        checkOutput("allocWhileFullID",    32'(bus.allocID), 0);
        checkOutput("allocWhileFullFlag",  32'(bus.full),    1);

        $display("[TB] out-of-order resolve, in-order drain");
        doReset();
        checkOutput("reset2Count", 32'(bus.count), 0);
        for (int i = 0; i < 3; i++) begin
            bus.allocValid = 1'b1;
            applyStimulus();
        end
        writeback(1, 'h104, 'h300, 0, 2);
        applyStimulus();
        writeback(0, 'h100, 'h200, 1, 1);
        applyStimulus();
        checkOutput("noCommitUpdateEn", 32'(bus.updateEn), 0);
        bus.commitCti = 1'b1;
        applyStimulus();
        checkOutput("drain0En",   32'(bus.updateEn),   1);
        checkOutput("drain0PC",   32'(bus.updatePC),   'h100);
        checkOutput("drain0NPC",  32'(bus.updateNPC),  'h200);
        checkOutput("drain0Dir",  32'(bus.updateDir),  1);
        checkOutput("drain0Type", 32'(bus.updateType), 1);
        checkOutput("drain0Count",32'(bus.count),      2);
        bus.commitCti = 1'b1;
        applyStimulus();
        checkOutput("drain1En",   32'(bus.updateEn),   1);
        checkOutput("drain1PC",   32'(bus.updatePC),   'h104);
        checkOutput("drain1NPC",  32'(bus.updateNPC),  'h300);
        checkOutput("drain1Dir",  32'(bus.updateDir),  0);
        checkOutput("drain1Type", 32'(bus.updateType), 2);
        checkOutput("drain1Count",32'(bus.count),      1);
        applyStimulus();
        checkOutput("pulseEnds",  32'(bus.updateEn),   0);
        checkOutput("fieldsHold", 32'(bus.updatePC),   'h104);
        checkOutput("noProtoErr", 32'(bus.protoErr),   0);

        $display("[TB] protocol errors and head bypass");
        doReset();
        bus.commitCti = 1'b1;
        applyStimulus();
        checkOutput("emptyCommitErr", 32'(bus.protoErr), 1);
        checkOutput("emptyCommitEn",  32'(bus.updateEn), 0);
        doReset();
        checkOutput("resetClearsErr", 32'(bus.protoErr), 0);
        bus.allocValid = 1'b1;
        applyStimulus();
        bus.commitCti = 1'b1;
        applyStimulus();
        checkOutput("unresolvedErr",   32'(bus.protoErr), 1);
        checkOutput("unresolvedCount", 32'(bus.count),    1);
        checkOutput("unresolvedEn",    32'(bus.updateEn), 0);
        writeback(0, 'h100, 'h200, 1, 1);
        bus.commitCti = 1'b1;
        applyStimulus();
        checkOutput("bypassEn",    32'(bus.updateEn), 1);
        checkOutput("bypassPC",    32'(bus.updatePC), 'h100);
        checkOutput("bypassCount", 32'(bus.count),    0);
        checkOutput("errSticky",   32'(bus.protoErr), 1);

        $display("[TB] recovery");
        doReset();
        for (int i = 0; i < 6; i++) begin
            bus.allocValid = 1'b1;
            applyStimulus();
        end
        bus.recoverFlag  = 1'b1;
        bus.recoverCtiID = 4'd2;
        bus.allocValid   = 1'b1;
        applyStimulus();
        checkOutput("recoverCount",   32'(bus.count),   3);
        checkOutput("recoverAllocID", 32'(bus.allocID), 3);
        writeback(4, 'hDEAD, 'hBEEF, 1, 3);
        applyStimulus();
        checkOutput("droppedWbCount", 32'(bus.count), 3);
        writeback(0, 'hAA, 'hBB, 0, 0);
        applyStimulus();
        bus.recoverFlag  = 1'b1;
        bus.recoverCtiID = 4'd1;
        bus.commitCti    = 1'b1;
        applyStimulus();
        checkOutput("recCommitCount",   32'(bus.count),    1);
        checkOutput("recCommitAllocID", 32'(bus.allocID),  2);
        checkOutput("recCommitEn",      32'(bus.updateEn), 1);
        checkOutput("recCommitPC",      32'(bus.updatePC), 'hAA);

        $display("[TB] ring wrap");
        doReset();
        bus.allocValid = 1'b1;
        applyStimulus();
        for (int k = 0; k < 20; k++) begin
            checkOutput("wrapAllocID", 32'(bus.allocID), (k + 1) % 16);
            bus.allocValid = 1'b1;
            bus.commitCti  = 1'b1;
            writeback(k % 16, 'h1000 + k, 'h2000 + k, k % 2, k % 4);
            applyStimulus();
            checkOutput("wrapUpdateEn", 32'(bus.updateEn), 1);
            checkOutput("wrapUpdatePC", 32'(bus.updatePC), 'h1000 + k);
            checkOutput("wrapCount",    32'(bus.count),    1);
            checkOutput("wrapFull",     32'(bus.full),     0);
        end

        $display("[TB] exception flush");
        writeback(4, 'h4444, 'h5555, 1, 3);
        bus.allocValid = 1'b1;
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            bus.allocValid = 1'b1;
            applyStimulus();
        end
        checkOutput("preExcCount", 32'(bus.count), 5);
        bus.exceptionFlag = 1'b1;
        bus.recoverFlag   = 1'b1;
        bus.recoverCtiID  = 4'd7;
        bus.commitCti     = 1'b1;
        bus.allocValid    = 1'b1;
        applyStimulus();
        checkOutput("excCount",   32'(bus.count),    0);
        checkOutput("excFull",    32'(bus.full),     0);
        checkOutput("excAllocID", 32'(bus.allocID),  5);
        checkOutput("excUpdEn",   32'(bus.updateEn), 1);
        checkOutput("excUpdPC",   32'(bus.updatePC), 'h4444);
        writeback(5, 'h1, 'h2, 0, 0);
        bus.commitCti = 1'b1;
        applyStimulus();
        checkOutput("emptyWbCommitErr", 32'(bus.protoErr), 1);
        checkOutput("emptyWbCommitEn",  32'(bus.updateEn), 0);
        checkOutput("emptyWbCount",     32'(bus.count),    0);

        $display("[TB] reset kills in-flight update");
        bus.allocValid = 1'b1;
        applyStimulus();
        writeback(5, 'h77, 'h88, 1, 1);
        applyStimulus();
        bus.commitCti = 1'b1;
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("rstPulseEn",  32'(bus.updateEn), 0);
        checkOutput("rstPulsePC",  32'(bus.updatePC), 0);
        checkOutput("rstPulseErr", 32'(bus.protoErr), 0);
        checkOutput("rstPulseCnt", 32'(bus.count),    0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
